// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory path: funct3 access sizes, responder
// FSM states and per-size byte/alignment helpers.
package mem_pkg;

  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;
  localparam logic [2:0] SZ_D   = 3'b011;
  localparam logic [2:0] SZ_BU  = 3'b100;
  localparam logic [2:0] SZ_HU  = 3'b101;
  localparam logic [2:0] SZ_WU  = 3'b110;
  localparam logic [2:0] SZ_INV = 3'b111;

  localparam logic [3:0] BYTES_B = 4'd1;
  localparam logic [3:0] BYTES_H = 4'd2;
  localparam logic [3:0] BYTES_W = 4'd4;
  localparam logic [3:0] BYTES_D = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // size[1:0] alone selects the width; size[2] only picks zero-extension.
  function automatic logic [3:0] access_bytes(input logic [1:0] width);
    case (width)
      2'b00:   return BYTES_B;
      2'b01:   return BYTES_H;
      2'b10:   return BYTES_W;
      default: return BYTES_D;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] width);
    case (width)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] width);
    return 3'(access_bytes(width) - 4'd1);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed bytes of a little-endian doubleword and sign- or
// zero-extends them to 64 bits according to the funct3 load size.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] dword_i,
  input  logic [2:0]  lane_i,
  input  logic [2:0]  size_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted;

  assign shifted = dword_i >> {lane_i, 3'b000};

  always_comb begin
    // NOTE: result_o gets a value on every path (default arm included) so no latch is inferred.
    case (size_i)
      SZ_B:    result_o = {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    result_o = {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    result_o = {{32{shifted[31]}}, shifted[31:0]};
      SZ_D:    result_o = shifted;
      SZ_BU:   result_o = {56'd0, shifted[7:0]};
      SZ_HU:   result_o = {48'd0, shifted[15:0]};
      SZ_WU:   result_o = {32'd0, shifted[31:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, fixed latency
// from accept to response, byte-enabled little-endian doubleword storage.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int CW    = $clog2(LATENCY + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q;
  logic [63:0]   addr_q;
  logic [2:0]    size_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q, rdata_d;
  logic          error_q, error_d;
  logic [63:0]   mem_q [WORDS];

  logic          accept;
  logic          mem_we;
  logic [2:0]    lane;
  logic [AW-4:0] word_idx;
  logic          misaligned, out_of_range, bad_size, access_err;
  logic [7:0]    byte_en;
  logic [63:0]   wdata_lane;
  logic [63:0]   load_data;

  assign accept   = (state_q == IDLE) && req_valid;
  assign lane     = addr_q[2:0];
  assign word_idx = addr_q[AW-1:3];

  assign misaligned   = |(lane & align_mask(size_q[1:0]));
  assign out_of_range = (|addr_q[63:AW]) ||
                        (({1'b0, addr_q[AW-1:0]} + (AW+1)'(access_bytes(size_q[1:0])))
                          > (AW+1)'(DEPTH_BYTES));
  assign bad_size     = (size_q == SZ_INV) || (write_q && size_q[2]);
  assign access_err   = misaligned || out_of_range || bad_size;

  assign byte_en    = 8'(byte_mask(size_q[1:0]) << lane);
  assign wdata_lane = wdata_q << {lane, 3'b000};

  load_extend u_load_extend (
    .dword_i  (mem_q[word_idx]),
    .lane_i   (lane),
    .size_i   (size_q),
    .result_o (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d   = CW'(LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) begin
        // Access resolves on the edge that raises rsp_valid.
        state_d = RESP;
        error_d = access_err;
        rdata_d = (access_err || write_q) ? '0 : load_data;
        mem_we  = write_q && !access_err;
      end else begin
        cnt_d = CW'(cnt_q - 1'b1);
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  // NOTE: storage has no reset so it maps onto plain RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule
